// File: rtl/pc_ctrl_pkg.sv
// Shared types and constants for the PC / instruction-fetch sequencer.
package pc_ctrl_pkg;

  localparam int unsigned InstWidth = 32;

  localparam logic [31:0] DefResetVec = 32'h0040_0000;
  localparam logic [31:0] DefExcVec   = 32'h0040_0004;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt
  } fetch_state_e;

  // Encoding is ordered by priority so a plain magnitude compare picks the winner.
  typedef enum logic [1:0] {
    CauseNone = 2'd0,
    CauseBr   = 2'd1,
    CauseJmp  = 2'd2,
    CauseExc  = 2'd3
  } redir_cause_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: merges live redirect inputs with the latched redirect,
// flags misaligned targets and produces the PC to load.
module pc_next_sel
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = DefExcVec
) (
  input  logic [31:0]  pc_i,
  input  logic         exc_i,
  input  logic         jmp_i,
  input  logic [31:0]  jmp_target_i,
  input  logic         br_taken_i,
  input  logic [31:0]  br_target_i,
  input  redir_cause_e latch_cause_i,
  input  logic [31:0]  latch_target_i,
  output redir_cause_e sel_cause_o,
  output logic [31:0]  sel_target_o,
  output logic [31:0]  next_pc_o,
  output logic         redirect_active_o,
  output logic         misaligned_o
);

  redir_cause_e new_cause;
  logic [31:0]  new_target;

  // Pick the highest-priority live redirect, then let it override the latch only
  // if strictly higher; the earlier latched redirect wins ties.
  always_comb begin
    new_cause  = CauseNone;
    new_target = '0;
    if (exc_i) begin
      new_cause  = CauseExc;
      new_target = EXC_VEC;
    end else if (jmp_i) begin
      new_cause  = CauseJmp;
      new_target = jmp_target_i;
    end else if (br_taken_i) begin
      new_cause  = CauseBr;
      new_target = br_target_i;
    end

    sel_cause_o  = latch_cause_i;
    sel_target_o = latch_target_i;
    if (new_cause > latch_cause_i) begin
      sel_cause_o  = new_cause;
      sel_target_o = new_target;
    end

    redirect_active_o = (sel_cause_o != CauseNone);
    misaligned_o      = redirect_active_o && (sel_target_o[1:0] != 2'b00);

    if (!redirect_active_o) begin
      next_pc_o = pc_i + 32'd4;
    end else if (misaligned_o) begin
      next_pc_o = EXC_VEC;
    end else begin
      next_pc_o = sel_target_o;
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and single-outstanding instruction fetch sequencer.
module pc_fetch_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DefResetVec,
  parameter logic [31:0] EXC_VEC   = DefExcVec,
  parameter int unsigned TIMEOUT   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 exc,
  input  logic                 jmp,
  input  logic [31:0]          jmp_target,
  input  logic                 br_taken,
  input  logic [31:0]          br_target,
  output logic                 imem_req,
  output logic [31:0]          imem_addr,
  input  logic                 imem_ack,
  input  logic [InstWidth-1:0] imem_rdata,
  output logic [InstWidth-1:0] inst,
  output logic                 inst_valid,
  output logic [31:0]          pc,
  output logic                 fetch_err
);

  fetch_state_e         state_q, state_d;
  logic [31:0]          pc_q, pc_d;
  logic [InstWidth-1:0] inst_q, inst_d;
  logic                 inst_valid_q, inst_valid_d;
  logic                 fetch_err_q, fetch_err_d;
  logic [7:0]           cnt_q, cnt_d;
  redir_cause_e         lat_cause_q, lat_cause_d;
  logic [31:0]          lat_target_q, lat_target_d;

  redir_cause_e sel_cause;
  logic [31:0]  sel_target;
  logic [31:0]  next_pc;
  logic         redirect_active;
  logic         misaligned;

  pc_next_sel #(
    .EXC_VEC (EXC_VEC)
  ) u_next_sel (
    .pc_i              (pc_q),
    .exc_i             (exc),
    .jmp_i             (jmp),
    .jmp_target_i      (jmp_target),
    .br_taken_i        (br_taken),
    .br_target_i       (br_target),
    .latch_cause_i     (lat_cause_q),
    .latch_target_i    (lat_target_q),
    .sel_cause_o       (sel_cause),
    .sel_target_o      (sel_target),
    .next_pc_o         (next_pc),
    .redirect_active_o (redirect_active),
    .misaligned_o      (misaligned)
  );

  // Next-state logic for the FSM, PC, delivered instruction, timeout and redirect latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = 1'b0;
    fetch_err_d  = 1'b0;
    cnt_d        = cnt_q;
    lat_cause_d  = lat_cause_q;
    lat_target_d = lat_target_q;

    unique case (state_q)
      StIdle: begin
        if (redirect_active) begin
          pc_d        = next_pc;
          fetch_err_d = misaligned;
        end
        if (halt) begin
          state_d = StHalt;
        end else if (!stall) begin
          state_d = StFetch;
        end
        cnt_d        = '0;
        lat_cause_d  = CauseNone;
        lat_target_d = '0;
      end
      StFetch: begin
        if (imem_ack) begin
          pc_d = next_pc;
          if (redirect_active) begin
            // Word fetched alongside or after a redirect is dropped (no delay slot).
            fetch_err_d = misaligned;
          end else begin
            inst_d       = imem_rdata;
            inst_valid_d = 1'b1;
          end
          if (halt) begin
            state_d = StHalt;
          end else if (stall) begin
            state_d = StIdle;
          end else begin
            state_d = StFetch;
          end
          cnt_d        = '0;
          lat_cause_d  = CauseNone;
          lat_target_d = '0;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          fetch_err_d  = 1'b1;
          pc_d         = EXC_VEC;
          state_d      = StIdle;
          cnt_d        = '0;
          lat_cause_d  = CauseNone;
          lat_target_d = '0;
        end else begin
          // Address stays fixed mid-request; redirects wait in the latch.
          cnt_d        = cnt_q + 8'd1;
          lat_cause_d  = sel_cause;
          lat_target_d = sel_target;
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous reset; a reset edge overrides any concurrent ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pc_q         <= RESET_VEC;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
      cnt_q        <= '0;
      lat_cause_q  <= CauseNone;
      lat_target_q <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      fetch_err_q  <= fetch_err_d;
      cnt_q        <= cnt_d;
      lat_cause_q  <= lat_cause_d;
      lat_target_q <= lat_target_d;
    end
  end

  assign imem_req   = (state_q == StFetch);
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios followed by random
// traffic, all compared each cycle against a behavioural model of the fetch rules.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0040_0004;
  localparam int          TIMEOUT   = 8;

  localparam int MIdle   = 0;
  localparam int MBusy   = 1;
  localparam int MHalted = 2;

  logic        clk = 1'b0;
  logic        rst, stall, halt, exc, jmp, br_taken, imem_ack;
  logic [31:0] jmp_target, br_target, imem_rdata;
  logic        imem_req, inst_valid, fetch_err;
  logic [31:0] imem_addr, inst, pc;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int          m_mode;
  int          m_waited;
  int          m_pend_p;
  logic [31:0] m_pend_t;
  logic [31:0] m_pc, m_inst;
  logic        m_valid, m_err;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(
    .RESET_VEC (RESET_VEC),
    .EXC_VEC   (EXC_VEC),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .halt       (halt),
    .exc        (exc),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst       (inst),
    .inst_valid (inst_valid),
    .pc         (pc),
    .fetch_err  (fetch_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic load_target(input logic [31:0] t);
    if (t[1:0] != 2'b00) begin
      m_pc  = EXC_VEC;
      m_err = 1'b1;
    end else begin
      m_pc = t;
    end
  endtask

  // Apply one clock edge of the fetch rules to the model, from the inputs now driven.
  task automatic model_step();
    int          np, cp;
    logic [31:0] nt, ct;
    np = 0;
    nt = '0;
    if (exc) begin
      np = 3; nt = EXC_VEC;
    end else if (jmp) begin
      np = 2; nt = jmp_target;
    end else if (br_taken) begin
      np = 1; nt = br_target;
    end
    if (np > m_pend_p) begin
      cp = np; ct = nt;
    end else begin
      cp = m_pend_p; ct = m_pend_t;
    end
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (rst) begin
      m_pc = RESET_VEC; m_inst = '0; m_mode = MIdle;
      m_waited = 0; m_pend_p = 0; m_pend_t = '0;
    end else if (m_mode == MIdle) begin
      if (cp > 0) load_target(ct);
      if (halt) m_mode = MHalted;
      else if (!stall) m_mode = MBusy;
    end else if (m_mode == MBusy) begin
      if (imem_ack) begin
        if (cp > 0) begin
          load_target(ct);
        end else begin
          m_inst  = imem_rdata;
          m_valid = 1'b1;
          m_pc    = m_pc + 32'd4;
        end
        m_waited = 0; m_pend_p = 0; m_pend_t = '0;
        if (halt) m_mode = MHalted;
        else if (stall) m_mode = MIdle;
      end else if (m_waited + 1 == TIMEOUT) begin
        m_err = 1'b1; m_pc = EXC_VEC; m_mode = MIdle;
        m_waited = 0; m_pend_p = 0; m_pend_t = '0;
      end else begin
        m_waited++;
        m_pend_p = cp;
        m_pend_t = ct;
      end
    end
  endtask

  // One clock: advance the model, take the edge, then compare all outputs.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("pc", pc, m_pc);
    chk("inst", inst, m_inst);
    chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_valid});
    chk("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
    chk("imem_req", {31'd0, imem_req}, {31'd0, (m_mode == MBusy)});
    if (m_mode == MBusy) chk("imem_addr", imem_addr, m_pc);
  endtask

  initial begin
    int ackp;
    m_mode = MIdle; m_waited = 0; m_pend_p = 0; m_pend_t = '0;
    m_pc = RESET_VEC; m_inst = '0; m_valid = 1'b0; m_err = 1'b0;
    rst = 1'b1; stall = 1'b0; halt = 1'b0; exc = 1'b0; jmp = 1'b0; br_taken = 1'b0;
    jmp_target = '0; br_target = '0; imem_ack = 1'b0; imem_rdata = '0;

    // Reset
    cycle();
    cycle();
    chk("reset_pc", pc, 32'h0040_0000);
    chk("reset_req", {31'd0, imem_req}, 32'd0);
    chk("reset_inst", inst, 32'd0);

    // Zero-wait memory: back-to-back fetches
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hA000_0001;
    cycle();
    chk("zw_addr0", imem_addr, 32'h0040_0000);
    chk("zw_req0", {31'd0, imem_req}, 32'd1);
    cycle();
    chk("zw_addr1", imem_addr, 32'h0040_0004);
    chk("zw_valid1", {31'd0, inst_valid}, 32'd1);
    chk("zw_inst1", inst, 32'hA000_0001);
    imem_rdata = 32'hA000_0002;
    cycle();
    chk("zw_addr2", imem_addr, 32'h0040_0008);
    chk("zw_valid2", {31'd0, inst_valid}, 32'd1);

    // Branch pulsed while the ack is delayed two cycles
    imem_ack = 1'b0; br_taken = 1'b1; br_target = 32'h0040_0100;
    cycle();
    br_taken = 1'b0;
    cycle();
    chk("br_addr_hold", imem_addr, 32'h0040_0008);
    imem_ack = 1'b1; imem_rdata = 32'hBAD0_0000;
    cycle();
    chk("br_valid", {31'd0, inst_valid}, 32'd0);
    chk("br_inst_hold", inst, 32'hA000_0002);
    chk("br_pc", pc, 32'h0040_0100);
    chk("br_next_addr", imem_addr, 32'h0040_0100);

    // exc, jmp and branch together: exception wins
    exc = 1'b1; jmp = 1'b1; jmp_target = 32'h0040_0200; br_taken = 1'b1;
    cycle();
    chk("prio_pc", pc, 32'h0040_0004);
    exc = 1'b0; jmp = 1'b0; br_taken = 1'b0;

    // Misaligned jump target
    jmp = 1'b1; jmp_target = 32'h0040_0202;
    cycle();
    chk("mis_err", {31'd0, fetch_err}, 32'd1);
    chk("mis_pc", pc, 32'h0040_0004);
    jmp = 1'b0;
    cycle();
    chk("mis_err_pulse", {31'd0, fetch_err}, 32'd0);

    // Timeout after TIMEOUT cycles without ack
    imem_ack = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) cycle();
    chk("to_err_early", {31'd0, fetch_err}, 32'd0);
    cycle();
    chk("to_err", {31'd0, fetch_err}, 32'd1);
    chk("to_req", {31'd0, imem_req}, 32'd0);
    chk("to_pc", pc, 32'h0040_0004);
    cycle();
    chk("to_err_pulse", {31'd0, fetch_err}, 32'd0);
    chk("to_restart", imem_addr, 32'h0040_0004);

    // Halt with a request outstanding
    halt = 1'b1;
    cycle();
    imem_ack = 1'b1; imem_rdata = 32'hC0DE_0001;
    cycle();
    chk("halt_valid", {31'd0, inst_valid}, 32'd1);
    chk("halt_req", {31'd0, imem_req}, 32'd0);
    imem_ack = 1'b0; exc = 1'b1;
    cycle();
    chk("halt_exc_pc", pc, 32'h0040_0008);
    exc = 1'b0;
    cycle();
    chk("halt_req_hold", {31'd0, imem_req}, 32'd0);

    // Reset mid-request drops a concurrent ack
    rst = 1'b1;
    cycle();
    rst = 1'b0; halt = 1'b0;
    cycle();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    cycle();
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);

    // Stall + jump in IDLE, then sequential wrap past the top of memory
    rst = 1'b0; stall = 1'b1; jmp = 1'b1; jmp_target = 32'hFFFF_FFFC; imem_ack = 1'b0;
    cycle();
    chk("idle_jmp_pc", pc, 32'hFFFF_FFFC);
    chk("idle_stall_req", {31'd0, imem_req}, 32'd0);
    jmp = 1'b0; stall = 1'b0;
    cycle();
    imem_ack = 1'b1;
    cycle();
    chk("wrap_pc", pc, 32'h0000_0000);
    chk("wrap_err", {31'd0, fetch_err}, 32'd0);

    // Random traffic
    ackp = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 64 == 0) begin
        case ($urandom_range(0, 2))
          0:       ackp = 3;
          1:       ackp = 40;
          default: ackp = 100;
        endcase
      end
      rst        = ($urandom_range(0, 99) < 1);
      stall      = ($urandom_range(0, 99) < 15);
      halt       = ($urandom_range(0, 299) < 1);
      exc        = ($urandom_range(0, 99) < 3);
      jmp        = ($urandom_range(0, 99) < 6);
      br_taken   = ($urandom_range(0, 99) < 8);
      jmp_target = {$urandom_range(0, 65535), 14'($urandom_range(0, 16383)), 2'b00};
      br_target  = {$urandom_range(0, 65535), 14'($urandom_range(0, 16383)), 2'b00};
      if ($urandom_range(0, 9) == 0) jmp_target[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) br_target[1:0] = 2'($urandom_range(1, 3));
      imem_ack   = ($urandom_range(0, 99) < ackp);
      imem_rdata = $urandom;
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencer for the 32-bit PC register and the instruction-memory fetch port of the single-issue CPU.
- Holds the PC and issues one fetch request at a time over a req/ack handshake.
- Delivers each fetched instruction with a one-cycle valid pulse.
- Selects the next PC from sequential (+4), branch, jump or exception redirects.
- Handles stall, halt, misaligned targets and fetch timeout.

Parameters:
RESET_VEC, 32'h0040_0000, PC value loaded on reset.
EXC_VEC, 32'h0040_0004, PC loaded on exception, misaligned target or fetch timeout.
TIMEOUT, 8, max cycles a request may wait for ack before fetch_err (range 1..255).

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-high.
stall  in  1  blocks issue of a new fetch request.
halt  in  1  stop fetching once any outstanding access completes.
exc  in  1  exception redirect to EXC_VEC.
jmp  in  1  jump redirect.
jmp_target  in  32  jump target.
br_taken  in  1  taken-branch redirect.
br_target  in  32  branch target.
imem_req  out  1  fetch request; held until ack.
imem_addr  out  32  fetch address, equal to pc while imem_req=1.
imem_ack  in  1  memory accepts and returns data this cycle.
imem_rdata  in  32  instruction word, valid with imem_ack.
inst  out  32  last delivered instruction.
inst_valid  out  1  one-cycle pulse; inst is new.
pc  out  32  current PC.
fetch_err  out  1  one-cycle pulse on timeout or misaligned target.

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_VEC, inst=0, inst_valid=0, fetch_err=0, imem_req=0.
  - State=IDLE, redirect latch cleared, timeout counter=0.
  - Reset mid-request drops the access; an ack in the same cycle is ignored.
- States: IDLE, FETCH, HALT.
- IDLE:
  - imem_req=0.
  - If halt=1, go to HALT.
  - Else, if stall=0, go to FETCH next cycle.
  - A redirect seen in IDLE loads pc=target at that edge.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Counter increments each cycle without ack.
- Ack edge in FETCH (imem_ack=1):
  - If no redirect is pending or present at this edge: inst<=imem_rdata, inst_valid<=1, pc<=pc+4.
  - Otherwise: the returned word is discarded (inst_valid stays 0, inst unchanged) and pc<=redirect target.
  - Next state: HALT if halt=1, else IDLE if stall=1, else FETCH (back-to-back fetch, 1 instr/cycle with a zero-wait memory).
- Redirects during FETCH without ack are latched, keeping the highest priority; imem_addr does not change mid-request.
- Redirect priority: exc > jmp > br_taken > sequential.
- No delay slot: an instruction fetched in the same cycle as, or after, a redirect is discarded.
- Misaligned target (target[1:0]!=0): pc<=EXC_VEC and fetch_err pulses at the edge where the target would load.
- Timeout: counter reaching TIMEOUT with no ack gives fetch_err=1 for one cycle, pc<=EXC_VEC, state IDLE, and clears the latch. The memory must tolerate the dropped request.
- Sequential PC wraps: 32'hFFFF_FFFC+4 = 32'h0000_0000, no error.
- HALT:
  - imem_req=0; all redirects are ignored.
  - pc holds its value.
  - Exits only by rst.
- Simultaneous stall and redirect in IDLE: the redirect loads pc; the stall only delays the request.

Decomposition:
- pc_ctrl_pkg holds:
  - the state enum (IDLE, FETCH, HALT);
  - the redirect-cause enum (NONE, BR, JMP, EXC);
  - the default vector constants;
  - the instruction-width constant 32.
- One sub-module, pc_next_sel (combinational):
  - inputs: pc, the redirect inputs and the latch;
  - outputs: next_pc, redirect_active and misaligned.
  - pc_fetch_ctrl keeps the FSM, counter, latch and registers.

Test Plan:
- Reset then zero-wait memory (ack tied 1, stall=0): imem_addr = 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; inst_valid high on each cycle from the first ack edge onward.
- Memory with 2-cycle ack latency, br_taken=1 and br_target=0x00400100 pulsed during the wait: at the ack, inst_valid=0, inst unchanged, and pc=0x00400100; the next request has addr=0x00400100.
- exc, jmp (jmp_target=0x00400200) and br_taken all asserted on the same edge: pc=0x00400004.
- jmp_target=0x00400202: fetch_err pulses for one cycle and pc=0x00400004.
- Ack withheld for 8 cycles with TIMEOUT=8: fetch_err pulses once, imem_req drops, pc=0x00400004, and fetching restarts from there.
- halt=1 while a request is outstanding: the access completes with inst_valid=1, then imem_req stays 0 and a later exc pulse is ignored. rst=1 mid-FETCH: at that edge pc=0x00400000 and the concurrent ack is ignored.
